// File: rtl/uart_transceiver.sv
// UART transceiver: 2-flop RX synchroniser, FWFT receive FIFO, independent TX.
// Define UART_PARITY_EN to add an even-parity bit in both directions.
module uart_transceiver #(
    parameter int CLKS_PER_BIT  = 260,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_out
);
    localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH     = CW'(RX_FIFO_DEPTH);
    localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   BIT_HALF  = 16'(CLKS_PER_BIT / 2);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA,
`ifdef UART_PARITY_EN
        R_PARITY,
`endif
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA,
`ifdef UART_PARITY_EN
        T_PARITY,
`endif
        T_STOP
    } tx_state_t;

    // ---------------- receive ----------------
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    rx_state_t            rx_state, rx_state_n;
    logic [15:0]          rx_cnt, rx_cnt_n;
    logic [2:0]           rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_perr, rx_perr_n;
    logic                 push, ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_perr  <= rx_perr_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_perr_n  = rx_perr;
        push       = 1'b0;
        ferr       = 1'b0;
        unique case (rx_state)
            R_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = R_START;
            end
            R_START: begin
                if (rx_cnt == BIT_HALF) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_perr_n  = 1'b0;
                    rx_state_n = rx_s2 ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = rx_idx + 3'd1;
                    rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_n = R_PARITY;
`else
                        rx_state_n = R_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            R_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_perr_n  = rx_s2 ^ (^rx_shift);
                    rx_state_n = R_STOP;
                end
            end
`endif
            R_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = R_IDLE;
                    if (rx_s2 && !rx_perr) push = 1'b1;
                    else                   ferr = 1'b1;
                end
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    // FWFT FIFO; a push into a full FIFO still lands if the head pops this cycle
    logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 pop, full, wr;

    assign rx_valid = (count != '0);
    assign rx_data  = mem[rd_ptr];
    assign pop      = rx_valid && rx_ready;
    assign full     = (count == DEPTH);
    assign wr       = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop)      count <= count + CW'(1);
            else if (!wr && pop) count <= count - CW'(1);
            rx_frame_err <= ferr;
            rx_overrun   <= push && full && !pop;
        end
    end

    // ---------------- transmit ----------------
    tx_state_t            tx_state, tx_state_n;
    logic [15:0]          tx_cnt, tx_cnt_n;
    logic [2:0]           tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_out_n, tx_done_n;
`ifdef UART_PARITY_EN
    logic                 tx_par, tx_par_n;

    always_ff @(posedge clk) begin
        if (rst) tx_par <= 1'b0;
        else     tx_par <= tx_par_n;
    end
`endif

    assign tx_busy = (tx_state != T_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_out   <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_out   <= tx_out_n;
            tx_done  <= tx_done_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_out_n   = tx_out;
        tx_done_n  = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        unique case (tx_state)
            T_IDLE: begin
                tx_cnt_n = '0;
                tx_out_n = 1'b1;
                if (tx_start) begin
                    tx_state_n = T_START;
                    tx_shift_n = tx_data;
                    tx_idx_n   = '0;
                    tx_out_n   = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_n   = ^tx_data;
`endif
                end
            end
            T_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = T_DATA;
                    tx_out_n   = tx_shift[0];
                end
            end
            T_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == DATA_LAST) begin
                        tx_idx_n   = '0;
`ifdef UART_PARITY_EN
                        tx_state_n = T_PARITY;
                        tx_out_n   = tx_par;
`else
                        tx_state_n = T_STOP;
                        tx_out_n   = 1'b1;
`endif
                    end else begin
                        tx_idx_n   = tx_idx + 3'd1;
                        tx_shift_n = tx_shift >> 1;
                        tx_out_n   = tx_shift[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            T_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = T_STOP;
                    tx_out_n   = 1'b1;
                end
            end
`endif
            T_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == STOP_LAST) begin
                        tx_state_n = T_IDLE;
                        tx_done_n  = 1'b1;
                    end else begin
                        tx_idx_n = tx_idx + 3'd1;
                    end
                end
            end
            default: tx_state_n = T_IDLE;
        endcase
    end
endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 260, clk cycles per bit (30 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, bits per character; legal range 5..8.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per TX frame; legal values 1, 2.
REQ-004 SHALL have parameter RX_FIFO_DEPTH, default 4, receive FIFO entries; power of two, legal range 2..64.
REQ-005 SHALL have ports, in order:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- rx_in  input  1  asynchronous serial input; idles high.
- rx_data  output  DATA_BITS  FIFO head character.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  pop request.
- rx_frame_err  output  1  one-cycle pulse: bad stop bit.
- rx_overrun  output  1  one-cycle pulse: character lost, FIFO full.
- tx_data  input  DATA_BITS  character to send.
- tx_start  input  1  send request.
- tx_busy  output  1  transmitter active.
- tx_done  output  1  one-cycle pulse: frame complete.
- tx_out  output  1  serial output; idles high.

Function
REQ-006 SHALL pass rx_in through a two-flop synchroniser before any use.
REQ-007 RX FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on synchronised high-to-low transition.
REQ-008 In START, the line SHALL be sampled at count CLKS_PER_BIT/2.
- Low: go to DATA.
- High: glitch; return to IDLE, no error flagged.
REQ-009 DATA SHALL sample DATA_BITS bits LSB first, one every CLKS_PER_BIT cycles from the mid-start sample; then go to STOP.
REQ-010 STOP SHALL sample one stop bit at mid-bit, then return to IDLE.
- High: character pushed to FIFO.
- Low: rx_frame_err pulses one cycle; character discarded.
- RX SHALL check exactly one stop bit regardless of STOP_BITS.
REQ-011 FIFO SHALL be first-word fall-through.
- rx_data valid whenever rx_valid=1.
- Pop occurs on a cycle with rx_valid && rx_ready.
- rx_ready while empty: no effect.
REQ-012 Push when full with no pop: character dropped, rx_overrun pulses one cycle, FIFO contents unchanged.
REQ-013 Push and pop in the same cycle when full: both SHALL succeed, no overrun.
REQ-014 Pointers SHALL wrap modulo RX_FIFO_DEPTH; count 0..RX_FIFO_DEPTH.
REQ-015 TX FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 tx_start sampled in IDLE: latch tx_data; tx_busy=1 and tx_out=0 from the next cycle.
REQ-017 tx_start while tx_busy=1 SHALL be ignored.
REQ-018 Frame SHALL be:
- start bit low;
- DATA_BITS bits LSB first;
- optional parity bit;
- STOP_BITS high bits;
- each bit CLKS_PER_BIT cycles.
REQ-019 In the cycle after the last stop bit:
- tx_busy SHALL deassert and tx_done SHALL pulse one cycle.
- A tx_start in that same cycle SHALL be accepted (back-to-back frames).
REQ-020 RX and TX SHALL operate fully independently, including loopback of tx_out to rx_in.

Reset
REQ-021 While rst=1: tx_out=1, tx_busy=0, tx_done=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, FIFO empty, both FSMs IDLE, counters 0.
REQ-022 Reset mid-frame SHALL abort both directions; tx_out high in the cycle after rst is sampled.
- rx_data value while rx_valid=0 is don't-care.

Configuration
REQ-023 Macro UART_PARITY_EN SHALL control even parity.
- Defined: TX appends even-parity bit after data.
- Defined: RX samples a parity bit before stop; mismatch counts as a frame error (rx_frame_err pulse, character discarded).
- Undefined: no parity bit in either direction; no PARITY states exist.

Verification
REQ-024 CLKS_PER_BIT=4, no parity. tx_start with tx_data=0xA5 at cycle 0 -> tx_out pattern 0,1,0,1,0,0,1,0,1,1, 4 cycles per bit, cycles 1..40; tx_done pulse at cycle 41.
REQ-025 Loopback; send 0x3C, 0xFF, 0x00 back-to-back, rx_ready=1 -> rx_data pops 0x3C, 0xFF, 0x00 in order; no error pulses.
REQ-026 Loopback, RX_FIFO_DEPTH=4, rx_ready=0; send 5 characters -> rx_overrun pulses once on 5th; pop 4 -> first 4 characters returned.
REQ-027 Drive rx_in 0x55 frame with stop bit low -> rx_frame_err pulse; rx_valid stays 0.
REQ-028 rx_in low pulse of 1 cycle -> no FIFO push, no error pulses.
REQ-029 UART_PARITY_EN defined: send 0x07 -> parity bit 1 on tx_out. Inject frame 0x07 with parity 0 on rx_in -> rx_frame_err pulse, character discarded.
